// File: rtl/instruction_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instruction_sequencer_pkg
// Purpose : Shared sizes, control-field layout and FSM encoding for the
//           instruction sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package instruction_sequencer_pkg;

  localparam int INSTRUCTION_MEMORY_FIELDS = 32;
  localparam int INSTRUCTION_MEMORY_WIDTH  = 32;
  localparam int INSTRUCTION_MEMORY_SIZE   = 2;

  localparam int END_BIT    = 0;
  localparam int REPEAT_LSB = 8;
  localparam int REPEAT_MSB = 15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    EXEC  = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : instruction_sequencer
// Purpose : Fetches wide instruction words, issues them over valid/ready and
//           repeats or advances the PC on execution-complete.
// Revision: 1.0 - initial release
// ============================================================================
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int INSTR_FIELDS = INSTRUCTION_MEMORY_FIELDS,
  parameter int FIELD_WIDTH  = INSTRUCTION_MEMORY_WIDTH,
  parameter int IM_SIZE      = INSTRUCTION_MEMORY_SIZE
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 stop,
  output logic [31:0]                          PC,
  input  logic [INSTR_FIELDS*FIELD_WIDTH-1:0]  instruction,
  output logic [INSTR_FIELDS*FIELD_WIDTH-1:0]  cfg_instruction,
  output logic                                 cfg_valid,
  input  logic                                 cfg_ready,
  input  logic                                 exec_done,
  output logic [7:0]                           repeat_index,
  output logic                                 busy,
  output logic                                 done
);

  localparam logic [31:0] PC_LAST = 32'(IM_SIZE - 1);

  seq_state_t state;
  seq_state_t state_next;
  logic [7:0] repeat_count;
  logic       end_flag;

  // The issued word is registered in FETCH, so its control field doubles
  // as the latched REPEAT/END for the whole lifetime of the instruction.
  assign repeat_count = cfg_instruction[REPEAT_MSB:REPEAT_LSB];
  assign end_flag     = cfg_instruction[END_BIT];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = ISSUE;
      ISSUE:   if (cfg_ready) state_next = EXEC;
      EXEC: begin
        if (exec_done) begin
          if (repeat_index < repeat_count)        state_next = ISSUE;
          else if (end_flag || (PC == PC_LAST))   state_next = DONE;
          else                                    state_next = FETCH;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (stop && (state != IDLE)) state_next = DONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      PC              <= '0;
      cfg_instruction <= '0;
      repeat_index    <= '0;
    end else begin
      state <= state_next;
      if (state == FETCH) cfg_instruction <= instruction;
      if ((state == IDLE) && (state_next == FETCH)) begin
        PC           <= '0;
        repeat_index <= '0;
      end
      if ((state == EXEC) && (state_next == ISSUE)) repeat_index <= repeat_index + 8'd1;
      if ((state == EXEC) && (state_next == FETCH)) begin
        PC           <= PC + 32'd1;
        repeat_index <= '0;
      end
      if (stop && (state != IDLE)) repeat_index <= '0;
    end
  end

  assign cfg_valid = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule
`default_nettype wire

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Downstream consumer of the instruction memory. Drives its 32-bit PC and reads back the 1024-bit wide instruction word.
- Registers the word and hands it to the datapath controller through a valid/ready handshake.
- Waits for execution-complete, then repeats the instruction or advances the PC until the program ends.
- Gives the core a start/busy/done program-level interface.

Parameters:
- INSTR_FIELDS, 32, number of 32-bit fields per instruction word.
- FIELD_WIDTH, 32, bits per field.
- IM_SIZE, 2, number of instruction words in the instruction memory; PC range is 0..IM_SIZE-1.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run the program from PC=0; honoured only in IDLE.
- stop  in  1  synchronous abort; forces DONE next cycle from any non-IDLE state.
- PC  out  32  instruction memory read address.
- instruction  in  INSTR_FIELDS*FIELD_WIDTH  combinational read data for PC.
- cfg_instruction  out  INSTR_FIELDS*FIELD_WIDTH  registered instruction presented to the datapath.
- cfg_valid  out  1  cfg_instruction is valid.
- cfg_ready  in  1  datapath accepts cfg_instruction.
- exec_done  in  1  one-cycle pulse: datapath finished the accepted instruction.
- repeat_index  out  8  current repetition number, 0-based.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the program ends or is aborted.

Behaviour:
- Reset (reset low, async): state=IDLE, PC=0, cfg_instruction=0, cfg_valid=0, repeat_index=0, busy=0, done=0.
- Control field is field 0, instruction[31:0]:
  - bit0 END: halt after this instruction.
  - bits15:8 REPEAT: execute REPEAT+1 times.
  - bits31:16 and 7:1 reserved, ignored.
  - Other fields pass through untouched.
- IDLE: start=1 -> FETCH, with PC=0 and repeat_index=0.
- FETCH, one cycle: cfg_instruction <= instruction (memory read at current PC); latched REPEAT and END captured -> ISSUE.
- ISSUE:
  - cfg_valid=1 and held stable until cfg_ready=1.
  - The handshake completes in the cycle where valid&&ready; cfg_valid deasserts next cycle -> EXEC.
- EXEC: wait for exec_done. On exec_done:
  - if repeat_index < REPEAT: repeat_index+1 -> ISSUE, with no refetch; the same cfg_instruction is re-presented.
  - else if END=1 or PC==IM_SIZE-1: -> DONE.
  - else PC+1, repeat_index=0 -> FETCH.
- DONE, one cycle: done=1, busy=0 next cycle, PC held, cfg_valid=0 -> IDLE.
- exec_done outside EXEC is ignored.
- start outside IDLE is ignored.
- stop has priority over every other transition: next state DONE, cfg_valid forced 0 next cycle, repeat_index cleared. stop in IDLE is ignored.
- PC never exceeds IM_SIZE-1; the upper bits of the 32-bit PC stay 0.
- Latency:
  - start to first cfg_valid: 2 cycles (IDLE->FETCH->ISSUE).
  - exec_done to next cfg_valid: 1 cycle on a repeat, 2 cycles on an advance.
- Instruction memory writes during a run are not tracked. A new word is seen only at the next FETCH.
- Reset asserted mid-run returns to the reset values immediately, with no done pulse.

Decomposition:
- Shared parameters package holds:
  - INSTRUCTION_MEMORY_FIELDS, INSTRUCTION_MEMORY_WIDTH, INSTRUCTION_MEMORY_SIZE.
  - Control-field bit positions: END_BIT=0, REPEAT_LSB=8, REPEAT_MSB=15.
  - The state encoding: IDLE, FETCH, ISSUE, EXEC, DONE.
- Single module. No sub-module is warranted; the FSM plus the PC and repeat counters are small.

Test Plan:
- Reset then idle: reset low mid-operation -> all outputs 0 within the same cycle; start ignored while reset is low.
- Two-instruction program, word0 ctrl=0x00000000, word1 ctrl=0x00000001, cfg_ready tied 1, exec_done 3 cycles after accept:
  - cfg_valid seen twice, first with PC=0 and then with PC=1.
  - done pulses one cycle after the second exec_done.
- Repeat: word0 ctrl=0x00000301 (REPEAT=3, END):
  - four handshakes, repeat_index 0,1,2,3 in turn.
  - cfg_instruction unchanged across them; PC stays 0; then done.
- Backpressure: cfg_ready low for 5 cycles in ISSUE -> cfg_valid and cfg_instruction stay stable; single accept when ready rises.
- Abort: stop asserted in EXEC -> done next cycle, then IDLE, cfg_valid=0; later exec_done ignored; a new start restarts at PC=0.
- Boundary: word1 has END=0 and IM_SIZE=2 -> the program ends after PC=1, PC never reads 2; spurious start and exec_done in the wrong states have no effect.
